// File: rtl/seq_mult_ctrl_pkg.sv
// rtl/seq_mult_ctrl_pkg.sv - shared widths, state encoding and helpers for the shift-add multiplier
package seq_mult_ctrl_pkg;

  // Default operand widths used by the top and the datapath
  localparam int MULT_M_W = 2;
  localparam int MULT_Q_W = 3;

  // Controller state encoding; 2'd3 is unused and treated as illegal
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit counter width: one extra bit above what is needed to index Q_W steps
  function automatic int cnt_width(input int q_w);
    return $clog2(q_w) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_shift_add_dp.sv
// rtl/seq_mult_ctrl_shift_add_dp.sv - shared shift-add datapath: accumulator, shifted multiplicand, shifted multiplier
module shift_add_dp
  import seq_mult_ctrl_pkg::*;
#(
  parameter int M_W = MULT_M_W,
  parameter int Q_W = MULT_Q_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [M_W-1:0]     i_m_in,
  input  logic [Q_W-1:0]     i_q_in,
  output logic [M_W+Q_W-1:0] o_acc,
  output logic [M_W+Q_W-1:0] o_sum,
  output logic               o_q_lsb
);

  localparam int P_W = M_W + Q_W;

  logic [P_W-1:0] r_acc;
  logic [P_W-1:0] r_m_sh;
  logic [Q_W-1:0] r_q_sh;
  logic [P_W-1:0] w_addend;

  // Add the shifted multiplicand only when the current multiplier bit is set;
  // the sum is exposed so the controller can capture the final step's result
  always_comb begin
    w_addend = '0;
    if (r_q_sh[0]) begin
      w_addend = r_m_sh;
    end
  end

  assign o_sum   = r_acc + w_addend;
  assign o_acc   = r_acc;
  assign o_q_lsb = r_q_sh[0];

  // Load operands on an accepted start, otherwise retire one multiplier bit per step
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_m_sh <= '0;
      r_q_sh <= '0;
    end else if (i_load) begin
      r_acc  <= '0;
      r_m_sh <= {{Q_W{1'b0}}, i_m_in};
      r_q_sh <= i_q_in;
    end else if (i_step) begin
      r_acc  <= o_sum;
      r_m_sh <= r_m_sh << 1;
      r_q_sh <= r_q_sh >> 1;
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - sequential multiplier controller with start/done handshake
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
#(
  parameter int M_W = MULT_M_W,
  parameter int Q_W = MULT_Q_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [M_W-1:0]     m_in,
  input  logic [Q_W-1:0]     q_in,
  output logic               busy,
  output logic               done,
  output logic [M_W+Q_W-1:0] p
);

  localparam int P_W   = M_W + Q_W;
  localparam int CNT_W = cnt_width(Q_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(Q_W - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [P_W-1:0]   r_p;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [P_W-1:0]   w_acc;
  logic [P_W-1:0]   w_sum;
  logic             w_q_lsb;

  shift_add_dp #(
    .M_W (M_W),
    .Q_W (Q_W)
  ) u_dp (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_m_in  (m_in),
    .i_q_in  (q_in),
    .o_acc   (w_acc),
    .o_sum   (w_sum),
    .o_q_lsb (w_q_lsb)
  );

  // State register; reset aborts any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath controls; start is only looked at in IDLE, so it is
  // neither queued nor able to disturb a running job
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_last = w_step && (r_cnt == LAST_CNT);

  // Step counter; RUN leaves at Q_W-1 so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Product register captures the last step's sum and holds until the next job finishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
    end else if (w_last) begin
      r_p <= w_sum;
    end
  end

  // Status is decoded from the state register alone, so it never glitches with start
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  assign p = r_p;

  // The accumulator and multiplier LSB are observed only through the final sum
  logic w_unused;
  assign w_unused = ^{w_acc, w_q_lsb};

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb/tb_seq_mult_ctrl.sv - scoreboard bench for seq_mult_ctrl
module tb_seq_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] m_in;
  logic [2:0] q_in;
  logic       busy;
  logic       done;
  logic [4:0] p;

  int total = 0;
  int bad   = 0;
  int done_count = 0;
  logic [4:0] exp_q[$];

  seq_mult_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .m_in  (m_in),
    .q_in  (q_in),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  // Count done pulses at the edge that closes each done cycle
  always @(posedge clk) begin
    if (done) done_count++;
  end

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Issue one job at a negedge, push its expected product, wait for done, compare
  task automatic run_job(input int m, input int q, input string name);
    bit got;
    logic [4:0] exp;
    m_in  = 2'(m);
    q_in  = 3'(q);
    start = 1'b1;
    exp_q.push_back(5'(m * q));
    @(negedge clk);
    start = 1'b0;
    wait_done(10, got);
    exp = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s timeout m=%0d q=%0d no done", name, m, q);
    end else if (p !== exp) begin
      bad++;
      $display("FAIL %s m=%0d q=%0d p=%0d expected=%0d", name, m, q, p, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; m_in = 2'd3; q_in = 3'd7;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (p !== 5'd0) begin bad++; $display("FAIL reset_p got=%0d want=0", p); end
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_hold_busy got=%b want=0", busy); end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exhaustive;
    for (int q = 0; q < 8; q++) begin
      for (int m = 0; m < 4; m++) begin
        run_job(m, q, "exhaustive");
      end
    end
  endtask

  task automatic test_latency;
    logic [4:0] exp;
    m_in = 2'd3; q_in = 3'd7; start = 1'b1;
    exp_q.push_back(5'd21);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (done !== (c == 3)) begin
        bad++; $display("FAIL latency_done cycle=%0d got=%b want=%b", c, done, (c == 3));
      end
      total++;
      if (busy !== (c <= 3)) begin
        bad++; $display("FAIL latency_busy cycle=%0d got=%b want=%b", c, busy, (c <= 3));
      end
      if (c == 3) begin
        exp = exp_q.pop_front();
        total++;
        if (p !== exp) begin bad++; $display("FAIL latency_p got=%0d want=%0d", p, exp); end
      end
      if (c > 3) begin
        total++;
        if (p !== 5'd21) begin bad++; $display("FAIL latency_p_hold cycle=%0d got=%0d want=21", c, p); end
      end
    end
  endtask

  task automatic test_busy_protection;
    int base;
    bit got;
    logic [4:0] exp;
    base = done_count;
    m_in = 2'd2; q_in = 3'd5; start = 1'b1;
    exp_q.push_back(5'd10);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    m_in = 2'd3; q_in = 3'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10, got);
    exp = exp_q.pop_front();
    total++;
    if (!got) begin bad++; $display("FAIL busy_prot timeout no done"); end
    else if (p !== exp) begin bad++; $display("FAIL busy_prot_p got=%0d want=%0d", p, exp); end
    repeat (8) @(negedge clk);
    total++;
    if (done_count - base !== 1) begin
      bad++; $display("FAIL busy_prot_pulses got=%0d want=1", done_count - base);
    end
    total++;
    if (p !== 5'd10) begin bad++; $display("FAIL busy_prot_p_hold got=%0d want=10", p); end
  endtask

  task automatic test_reset_abort;
    int base;
    base = done_count;
    m_in = 2'd3; q_in = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    total++; if (p !== 5'd0) begin bad++; $display("FAIL abort_p got=%0d want=0", p); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (done_count !== base) begin bad++; $display("FAIL abort_no_done got=%0d want=%0d", done_count - base, 0); end
    run_job(1, 3, "abort_next");
  endtask

  task automatic test_back_to_back;
    int seen;
    int first_c;
    logic [4:0] exp;
    seen = 0;
    first_c = -1;
    m_in = 2'd2; q_in = 3'd3; start = 1'b1;
    exp_q.push_back(5'd6);
    exp_q.push_back(5'd3);
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      if (c == 0) begin
        m_in = 2'd3; q_in = 3'd1;
      end
      if (seen >= 1 && busy && !done) start = 1'b0;
      if (done) begin
        exp = exp_q.pop_front();
        total++;
        if (p !== exp) begin bad++; $display("FAIL b2b_p job=%0d got=%0d want=%0d", seen, p, exp); end
        if (seen == 0) begin
          first_c = c;
        end else begin
          total++;
          if (c - first_c !== 5) begin bad++; $display("FAIL b2b_gap got=%0d want=5", c - first_c); end
        end
        seen++;
      end
    end
    start = 1'b0;
    total++;
    if (seen !== 2) begin
      bad++; $display("FAIL b2b_count got=%0d want=2", seen);
      while (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_operand;
    bit got;
    logic [4:0] exp;
    got = 1'b0;
    m_in = 2'd0; q_in = 3'd7; start = 1'b1;
    exp_q.push_back(5'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        total++;
        if (c !== 3) begin bad++; $display("FAIL zero_latency got=%0d want=3", c); end
        break;
      end
      total++;
      if (p !== 5'd3) begin bad++; $display("FAIL zero_p_hold cycle=%0d got=%0d want=3", c, p); end
    end
    exp = exp_q.pop_front();
    total++;
    if (!got) begin bad++; $display("FAIL zero timeout no done"); end
    else if (p !== exp) begin bad++; $display("FAIL zero_p got=%0d want=%0d", p, exp); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_in = '0; q_in = '0;
    test_reset;
    test_exhaustive;
    test_latency;
    test_busy_protection;
    test_reset_abort;
    test_back_to_back;
    test_zero_operand;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
